// File: rtl/ntr_response_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ntr_response_tx_if
// Brief    : Word-stream handshake between the response generator and the
//            NTR response transmitter.
// Revision : 1.0
// ============================================================================
interface ntr_response_tx_if;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/ntr_response_tx.sv
`default_nettype none
// ============================================================================
// Module   : ntr_response_tx
// Brief    : Cartridge-side NTR reply transmitter; buffers 32-bit words and
//            drives them LSB byte first, one byte per ntr_clk falling edge.
// Revision : 1.0
// ============================================================================
module ntr_response_tx #(
    parameter int         SYNC_STAGES = 2,
    parameter int         LEN_W       = 12,
    parameter int         DEPTH       = 4,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ntr_clk,
    input  logic             ntr_cs_n,
    input  logic             start,
    input  logic [LEN_W-1:0] xfer_words,
    ntr_response_tx_if.slave wr,
    output logic [7:0]       ntr_data,
    output logic             ntr_oe,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Synchronisers reset to 1 so the bus reads as idle out of reset
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_clk_prev;
    logic                   r_cs_prev;
    logic                   w_fall;
    logic                   w_cs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= '1;
            r_cs_sync  <= '1;
            r_clk_prev <= 1'b1;
            r_cs_prev  <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ntr_clk};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], ntr_cs_n};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
            r_cs_prev  <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_cs_rise = ~r_cs_prev & r_cs_sync[SYNC_STAGES-1];

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [31:0]        r_sreg;
    logic [1:0]         r_idx;
    logic [7:0]         r_ntr_data;
    logic               r_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_underrun;

    logic [31:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_abort;
    logic [31:0]        w_word;

    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign wr.wr_ready = ~w_full;
    assign w_abort     = w_cs_rise & r_busy;
    assign w_push      = wr.wr_valid & ~w_full & ~w_abort;
    assign w_pop       = (r_state == S_LOAD) & ~w_empty & ~w_abort;
    assign w_word      = w_empty ? {4{FILL_BYTE}} : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_sreg      <= '0;
            r_idx       <= '0;
            r_ntr_data  <= 8'h00;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_oe    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_underrun <= 1'b0;
                            r_busy     <= 1'b1;
                            if (xfer_words != '0) begin
                                r_remaining <= xfer_words;
                                r_state     <= S_LOAD;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_sreg      <= w_word;
                        r_ntr_data  <= w_word[7:0];
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_idx       <= 2'd0;
                        r_oe        <= 1'b1;
                        r_state     <= S_SHIFT;
                        if (w_empty) r_underrun <= 1'b1;
                    end
                    S_SHIFT: begin
                        // The last byte stays on the pads through the next LOAD
                        if (w_fall) begin
                            if (r_idx != 2'd3) begin
                                r_sreg     <= r_sreg >> 8;
                                r_ntr_data <= r_sreg[15:8];
                                r_idx      <= r_idx + 2'd1;
                            end else if (r_remaining != '0) begin
                                r_state <= S_LOAD;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ntr_data = r_ntr_data;
    assign ntr_oe   = r_oe;
    assign busy     = r_busy;
    assign done     = r_done;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ntr_response_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntr_response_tx
// Brief    : Self-checking bench for ntr_response_tx against a byte-queue model.
// Revision : 1.0
// ============================================================================
module tb_ntr_response_tx;

    localparam int         SYNC_STAGES = 2;
    localparam int         LEN_W       = 12;
    localparam int         DEPTH       = 4;
    localparam logic [7:0] FILL_BYTE   = 8'hFF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ntr_clk = 1'b0;
    logic             ntr_cs_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] xfer_words = '0;
    logic [7:0]       ntr_data;
    logic             ntr_oe;
    logic             busy;
    logic             done;
    logic             underrun;

    ntr_response_tx_if wr_if ();

    ntr_response_tx #(
        .SYNC_STAGES (SYNC_STAGES),
        .LEN_W       (LEN_W),
        .DEPTH       (DEPTH),
        .FILL_BYTE   (FILL_BYTE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ntr_clk    (ntr_clk),
        .ntr_cs_n   (ntr_cs_n),
        .start      (start),
        .xfer_words (xfer_words),
        .wr         (wr_if),
        .ntr_data   (ntr_data),
        .ntr_oe     (ntr_oe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int done_cnt = 0;
    int busy_cnt = 0;
    int oe_cnt   = 0;
    always @(negedge clk) begin
        if (done)   done_cnt++;
        if (busy)   busy_cnt++;
        if (ntr_oe) oe_cnt++;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mq[$];
    logic [7:0]  exp_q[$];
    logic        exp_under = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model accepts a word only while it holds fewer than DEPTH
    task automatic push(input logic [31:0] w);
        @(negedge clk);
        chk("wr_ready", {31'd0, wr_if.wr_ready}, {31'd0, mq.size() < DEPTH});
        wr_if.wr_data  = w;
        wr_if.wr_valid = 1'b1;
        if (mq.size() < DEPTH) mq.push_back(w);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        logic [31:0] word;
        exp_q.delete();
        exp_under = 1'b0;
        for (int w = 0; w < n; w++) begin
            if (mq.size() != 0) word = mq.pop_front();
            else begin
                word      = {4{FILL_BYTE}};
                exp_under = 1'b1;
            end
            for (int b = 0; b < 4; b++) exp_q.push_back(word[8*b +: 8]);
        end
        @(negedge clk);
        start      = 1'b1;
        xfer_words = LEN_W'(n);
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic pulse(output logic [7:0] b, output logic oe);
        int hi = $urandom_range(4, 8);
        int lo = $urandom_range(4, 8);
        ntr_clk = 1'b1;
        repeat (hi) @(negedge clk);
        b  = ntr_data;
        oe = ntr_oe;
        ntr_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic shift_out(input string tag, input int nbytes, input bit expect_end);
        logic [7:0] b;
        logic       oe;
        int         d0 = done_cnt;
        for (int i = 0; i < nbytes; i++) begin
            pulse(b, oe);
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, b}, {24'd0, exp_q[i]});
            chk($sformatf("%s_oe%0d", tag, i), {31'd0, oe}, 32'd1);
        end
        if (expect_end) begin
            repeat (12) @(negedge clk);
            chk({tag, "_done"}, done_cnt - d0, 1);
            chk({tag, "_oe_off"}, {31'd0, ntr_oe}, 32'd0);
            chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
            chk({tag, "_underrun"}, {31'd0, underrun}, {31'd0, exp_under});
        end
    endtask

    initial begin
        int d0, b0, o0, n, k;
        bit gone;
        wr_if.wr_data  = '0;
        wr_if.wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, ntr_data}, 32'd0);
        chk("rst_oe", {31'd0, ntr_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Two preloaded words
        push(32'h44332211);
        push(32'h88776655);
        do_start(2);
        shift_out("two_word", 8, 1'b1);

        // Underrun, then a zero-length start clears the flag
        do_start(1);
        shift_out("underrun", 4, 1'b1);
        d0 = done_cnt; b0 = busy_cnt; o0 = oe_cnt;
        do_start(0);
        chk("zero_busy_now", {31'd0, busy}, 32'd1);
        chk("zero_underrun_clr", {31'd0, underrun}, 32'd0);
        @(negedge clk);
        chk("zero_done_now", {31'd0, done}, 32'd1);
        repeat (5) @(negedge clk);
        chk("zero_done_cnt", done_cnt - d0, 1);
        chk("zero_busy_cycles", busy_cnt - b0, 1);
        chk("zero_oe_cycles", oe_cnt - o0, 0);

        // Abort after five bytes of a three-word transfer
        push(32'hA3A2A1A0);
        push(32'hB3B2B1B0);
        push(32'hC3C2C1C0);
        do_start(3);
        shift_out("abort", 5, 1'b0);
        d0 = done_cnt;
        ntr_cs_n = 1'b1;
        gone = 1'b0;
        for (int i = 0; i < SYNC_STAGES + 2; i++) begin
            @(negedge clk);
            if (!ntr_oe && !busy) begin
                gone = 1'b1;
                break;
            end
        end
        chk("abort_stop", {31'd0, gone}, 32'd1);
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        chk("abort_underrun", {31'd0, underrun}, 32'd0);
        mq.delete();
        ntr_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        do_start(1);
        shift_out("post_flush", 4, 1'b1);

        // Fill to capacity; the extra push is dropped
        for (int i = 0; i < DEPTH + 1; i++) push(32'h10203040 + i);
        chk("full_ready", {31'd0, wr_if.wr_ready}, 32'd0);
        do_start(DEPTH);
        @(negedge clk);
        chk("full_ready_after_pop", {31'd0, wr_if.wr_ready}, 32'd1);
        shift_out("full", 4 * DEPTH, 1'b1);

        // Asynchronous reset in the middle of SHIFT
        push(32'hDEADBEEF);
        do_start(2);
        shift_out("pre_reset", 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_data", {24'd0, ntr_data}, 32'd0);
        chk("async_oe", {31'd0, ntr_oe}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        push(32'h0BADF00D);
        do_start(1);
        shift_out("after_reset", 4, 1'b1);

        // Randomized transfers
        for (int t = 0; t < 12; t++) begin
            k = $urandom_range(0, DEPTH + 1);
            n = $urandom_range(1, 5);
            for (int i = 0; i < k; i++) push($urandom);
            do_start(n);
            shift_out($sformatf("rnd%0d", t), 4 * n, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
